cga_vram_arbiter: RTL

- Owns the single external video SRAM port and shares it between two requesters: the pixel fetch path (display refresh, hard real-time) and the synchronized ISA CPU read/write path.
- Pixel fetch always wins; CPU accesses run only inside sequencer-granted slots and are retried if preempted.
- Generates the ISA ready (wait-state) handshake, with a watchdog that bounds how long ready can be held low.
- Sits between the sequencer/pixel pipeline, the ISA decode logic and the SRAM pins; it replaces the ad-hoc VRAM muxing in the card top level.

---
 rtl/cga_vram_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/cga_vram_arbiter.sv
// ---------------------------------------------------------------------------
// cga_vram_arbiter
// Owns the single video SRAM port and shares it between the pixel fetch path
// (hard real-time, always wins) and the synchronized ISA CPU read/write path
// (runs only in sequencer-granted slots, retried when preempted). Generates
// the ISA ready handshake with a watchdog bounding how long ready stays low.
//
// Ports:
//   clk, reset_l             card clock, asynchronous active-low reset
//   pixel_req/pixel_addr     pixel read strobe (one per byte) and address
//   pixel_data/pixel_valid   captured pixel byte, valid two cycles after req
//   slot_open                CPU access window granted this cycle
//   isa_rd/isa_wr            CPU read/write request levels (synchronized)
//   isa_addr/isa_din         CPU address and write data
//   isa_dout                 CPU read data, held until the next read completes
//   isa_rdy                  ISA ready (0 = insert wait states)
//   wait_timeout             sticky watchdog flag, cleared only by reset
//   ram_a/ram_d_out/ram_d_oe SRAM address, write data and data-bus drive
//   ram_d_in                 SRAM read data (valid one cycle after address)
//   ram_we_l                 SRAM write enable, active low
// ---------------------------------------------------------------------------
module cga_vram_arbiter #(
    parameter int USE_BUS_WAIT = 1,
    parameter int WAIT_MAX     = 200,
    parameter int ADDR_W       = 19
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              pixel_req,
    input  logic [ADDR_W-1:0] pixel_addr,
    output logic [7:0]        pixel_data,
    output logic              pixel_valid,
    input  logic              slot_open,
    input  logic              isa_rd,
    input  logic              isa_wr,
    input  logic [ADDR_W-1:0] isa_addr,
    input  logic [7:0]        isa_din,
    output logic [7:0]        isa_dout,
    output logic              isa_rdy,
    output logic              wait_timeout,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_d_out,
    output logic              ram_d_oe,
    input  logic [7:0]        ram_d_in,
    output logic              ram_we_l
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PEND     = 3'd1,
        S_RD_ADDR  = 3'd2,
        S_RD_CAP   = 3'd3,
        S_WR_SETUP = 3'd4,
        S_WR_PULSE = 3'd5,
        S_WR_HOLD  = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    // Last watchdog count value before the forced release fires.
    localparam logic [7:0] WD_LAST = 8'(WAIT_MAX - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_rd_prev;
    logic              r_wr_prev;
    logic              w_req_edge;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_din;
    logic              r_is_rd;
    logic              r_pix_d1;
    logic [7:0]        r_pixel_data;
    logic              r_pixel_valid;
    logic [7:0]        r_isa_dout;
    logic [ADDR_W-1:0] r_ram_a_hold;
    logic [7:0]        r_wd_cnt;
    logic              r_wd_release;
    logic              r_wait_timeout;
    logic              w_access;
    logic              w_rdy_raw;
    logic              w_we_l;
    logic              w_d_oe;
    logic [ADDR_W-1:0] w_ram_a;

    // A request only counts when the level was low in the previous cycle.
    assign w_req_edge = (isa_rd & ~r_rd_prev) | (isa_wr & ~r_wr_prev);

    // State register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; any pixel request during an access aborts it back to PEND.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_edge) w_next_state = S_PEND;
                else            w_next_state = S_IDLE;
            end
            S_PEND: begin
                if (slot_open && !pixel_req) w_next_state = r_is_rd ? S_RD_ADDR : S_WR_SETUP;
                else                         w_next_state = S_PEND;
            end
            S_RD_ADDR:  w_next_state = pixel_req ? S_PEND : S_RD_CAP;
            S_RD_CAP:   w_next_state = pixel_req ? S_PEND : S_DONE;
            S_WR_SETUP: w_next_state = pixel_req ? S_PEND : S_WR_PULSE;
            S_WR_PULSE: w_next_state = pixel_req ? S_PEND : S_WR_HOLD;
            S_WR_HOLD:  w_next_state = pixel_req ? S_PEND : S_DONE;
            S_DONE: begin
                if (!isa_rd && !isa_wr) w_next_state = S_IDLE;
                else                    w_next_state = S_DONE;
            end
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Output decode; write strobes are gated by pixel_req so an abort releases the bus at once.
    always_comb begin
        w_access  = 1'b0;
        w_rdy_raw = 1'b1;
        w_we_l    = 1'b1;
        w_d_oe    = 1'b0;
        case (r_state)
            S_PEND: begin
                w_rdy_raw = 1'b0;
            end
            S_RD_ADDR, S_RD_CAP: begin
                w_access  = 1'b1;
                w_rdy_raw = 1'b0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                w_access  = 1'b1;
                w_rdy_raw = 1'b0;
                w_d_oe    = ~pixel_req;
            end
            S_WR_PULSE: begin
                w_access  = 1'b1;
                w_rdy_raw = 1'b0;
                w_d_oe    = ~pixel_req;
                w_we_l    = pixel_req;
            end
            default: begin
                w_rdy_raw = 1'b1;
            end
        endcase
        if (pixel_req)     w_ram_a = pixel_addr;
        else if (w_access) w_ram_a = r_addr;
        else               w_ram_a = r_ram_a_hold;
    end

    // Request edge history and latching of the CPU request in IDLE.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_rd_prev <= 1'b0;
            r_wr_prev <= 1'b0;
            r_addr    <= '0;
            r_din     <= 8'h00;
            r_is_rd   <= 1'b0;
        end else begin
            r_rd_prev <= isa_rd;
            r_wr_prev <= isa_wr;
            if (r_state == S_IDLE && w_req_edge) begin
                r_addr  <= isa_addr;
                r_din   <= isa_din;
                r_is_rd <= isa_rd;
            end
        end
    end

    // Pixel capture pipeline, CPU read capture and ram_a hold register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_pix_d1      <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_pixel_data  <= 8'h00;
            r_isa_dout    <= 8'h00;
            r_ram_a_hold  <= '0;
        end else begin
            r_pix_d1      <= pixel_req;
            r_pixel_valid <= r_pix_d1;
            if (r_pix_d1) r_pixel_data <= ram_d_in;
            if (r_state == S_RD_CAP && !pixel_req) r_isa_dout <= ram_d_in;
            r_ram_a_hold  <= w_ram_a;
        end
    end

    // Watchdog: counts wait-state cycles and forces ready high once the limit is hit.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_wd_cnt       <= 8'd0;
            r_wd_release   <= 1'b0;
            r_wait_timeout <= 1'b0;
        end else if (w_rdy_raw || USE_BUS_WAIT == 0) begin
            r_wd_cnt     <= 8'd0;
            r_wd_release <= 1'b0;
        end else if (!r_wd_release) begin
            if (r_wd_cnt == WD_LAST) begin
                r_wd_release   <= 1'b1;
                r_wait_timeout <= 1'b1;
            end else begin
                r_wd_cnt <= r_wd_cnt + 8'd1;
            end
        end
    end

    assign isa_rdy      = (USE_BUS_WAIT == 0) ? 1'b1 : (w_rdy_raw | r_wd_release);
    assign wait_timeout = r_wait_timeout;
    assign ram_a        = w_ram_a;
    assign ram_d_out    = r_din;
    assign ram_d_oe     = w_d_oe;
    assign ram_we_l     = w_we_l;
    assign pixel_data   = r_pixel_data;
    assign pixel_valid  = r_pixel_valid;
    assign isa_dout     = r_isa_dout;

endmodule
